wham_round_ctrl: RTL and testbench

//  Whac-A-Mole game/round controller: picks moles pseudo-randomly, lights mole LEDs,

---
 rtl/wham_round_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_wham_round_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wham_round_ctrl.sv
// Whac-A-Mole round controller: paces moles on a ms timebase, picks them from an
// 8-bit LFSR, scores switch strikes and reports light/hit events to the displays.
module wham_round_ctrl #(
  parameter int         CLKS_PER_MS = 50000,
  parameter int         N_MOLES     = 10,
  parameter int         ROUNDS      = 30,
  parameter int         GAP_MS      = 500,
  parameter int         UP_MS_EASY  = 2000,
  parameter int         UP_MS_MED   = 1200,
  parameter int         UP_MS_HARD  = 700,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic [2:0]         diff_in,
  input  logic [N_MOLES-1:0] sw,
  output logic [N_MOLES-1:0] mole_led,
  output logic               start_evt,
  output logic               stop_evt,
  output logic [15:0]        score,
  output logic [2:0]         diff,
  output logic               playing
);

  localparam int          IDX_W     = $clog2(N_MOLES);
  localparam logic [15:0] SCORE_MAX = 16'd9999;

  typedef enum logic [1:0] {IDLE, GAP, UP} state_t;

  state_t             state_reg, state_next;
  logic [15:0]        clk_cnt_reg, clk_cnt_next;
  logic [15:0]        ms_cnt_reg, ms_cnt_next;
  logic [7:0]         lfsr_reg, lfsr_next;
  logic [N_MOLES-1:0] sw_q_reg;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               have_prev_reg, have_prev_next;
  logic [15:0]        round_reg, round_next;
  logic [15:0]        score_reg, score_next;
  logic [2:0]         diff_reg, diff_next;
  logic               playing_reg, playing_next;
  logic [N_MOLES-1:0] mole_led_reg, mole_led_next;
  logic               start_evt_reg, start_evt_next;
  logic               stop_evt_reg, stop_evt_next;

  logic [N_MOLES-1:0] sw_edge;
  logic               ms_tick, hit, wrong, gap_done, up_done;
  logic               enter, resolve;
  logic [15:0]        up_ms;
  logic [7:0]         lfsr_mod, pick;
  logic [2:0]         diff_sel;

  assign sw_edge  = sw ^ sw_q_reg;
  // The lit LED doubles as the target mask, so no indexed select is needed.
  assign hit      = |(sw_edge & mole_led_reg);
  assign wrong    = |(sw_edge & ~mole_led_reg);
  assign ms_tick  = (clk_cnt_reg == 16'(CLKS_PER_MS - 1));
  assign up_ms    = diff_reg[2] ? 16'(UP_MS_HARD) :
                    diff_reg[1] ? 16'(UP_MS_MED)  : 16'(UP_MS_EASY);
  assign gap_done = ms_tick && (ms_cnt_reg == 16'(GAP_MS - 1));
  assign up_done  = ms_tick && (ms_cnt_reg == up_ms - 16'd1);
  assign lfsr_mod = lfsr_reg % 8'(N_MOLES);
  assign pick     = (have_prev_reg && lfsr_mod == 8'(idx_reg)) ?
                    (lfsr_mod + 8'd1) % 8'(N_MOLES) : lfsr_mod;
  assign diff_sel = (diff_in == 3'b001 || diff_in == 3'b010 || diff_in == 3'b100) ?
                    diff_in : 3'b001;

  always_comb begin
    state_next     = state_reg;
    clk_cnt_next   = ms_tick ? 16'd0 : clk_cnt_reg + 16'd1;
    ms_cnt_next    = ms_tick ? ms_cnt_reg + 16'd1 : ms_cnt_reg;
    lfsr_next      = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    idx_next       = idx_reg;
    have_prev_next = have_prev_reg;
    round_next     = round_reg;
    score_next     = score_reg;
    diff_next      = diff_reg;
    playing_next   = playing_reg;
    mole_led_next  = mole_led_reg;
    start_evt_next = 1'b0;
    stop_evt_next  = 1'b0;
    enter          = 1'b0;
    resolve        = 1'b0;

    // A start press restarts from any state and overrides a same-cycle hit.
    if (start_btn) begin
      state_next    = GAP;
      score_next    = 16'd0;
      round_next    = 16'd0;
      diff_next     = diff_sel;
      playing_next  = 1'b1;
      mole_led_next = '0;
      enter         = 1'b1;
    end else begin
      case (state_reg)
        IDLE: ;
        GAP: begin
          if (gap_done) begin
            state_next     = UP;
            idx_next       = IDX_W'(pick);
            have_prev_next = 1'b1;
            mole_led_next  = N_MOLES'(1) << pick;
            start_evt_next = 1'b1;
            enter          = 1'b1;
          end
        end
        UP: begin
          if (hit) begin
            stop_evt_next = 1'b1;
            score_next    = (score_reg >= SCORE_MAX) ? SCORE_MAX : score_reg + 16'd1;
            resolve       = 1'b1;
          end else begin
            if (wrong)
              score_next = (score_reg == 16'd0) ? 16'd0 : score_reg - 16'd1;
            if (up_done)
              resolve = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (resolve) begin
      mole_led_next = '0;
      round_next    = round_reg + 16'd1;
      enter         = 1'b1;
      if (round_reg == 16'(ROUNDS - 1)) begin
        state_next   = IDLE;
        playing_next = 1'b0;
      end else begin
        state_next = GAP;
      end
    end

    if (enter) begin
      clk_cnt_next = 16'd0;
      ms_cnt_next  = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    sw_q_reg <= sw;
    if (rst) begin
      state_reg     <= IDLE;
      clk_cnt_reg   <= 16'd0;
      ms_cnt_reg    <= 16'd0;
      lfsr_reg      <= LFSR_SEED;
      idx_reg       <= '0;
      have_prev_reg <= 1'b0;
      round_reg     <= 16'd0;
      score_reg     <= 16'd0;
      diff_reg      <= 3'b001;
      playing_reg   <= 1'b0;
      mole_led_reg  <= '0;
      start_evt_reg <= 1'b0;
      stop_evt_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clk_cnt_reg   <= clk_cnt_next;
      ms_cnt_reg    <= ms_cnt_next;
      lfsr_reg      <= lfsr_next;
      idx_reg       <= idx_next;
      have_prev_reg <= have_prev_next;
      round_reg     <= round_next;
      score_reg     <= score_next;
      diff_reg      <= diff_next;
      playing_reg   <= playing_next;
      mole_led_reg  <= mole_led_next;
      start_evt_reg <= start_evt_next;
      stop_evt_reg  <= stop_evt_next;
    end
  end

  assign mole_led  = mole_led_reg;
  assign start_evt = start_evt_reg;
  assign stop_evt  = stop_evt_reg;
  assign score     = score_reg;
  assign diff      = diff_reg;
  assign playing   = playing_reg;

endmodule

// File: tb/tb_wham_round_ctrl.sv
// Directed game scenarios with randomized strike timing and switch choice, checked
// against a scoreboard of score/round/difficulty and an LFSR-driven mole picker.
module tb_wham_round_ctrl;

  localparam int         CPM    = 5;
  localparam int         NM     = 4;
  localparam int         ROUNDS = 3;
  localparam int         GAP    = 2;
  localparam int         EASY   = 6;
  localparam int         MED    = 4;
  localparam int         HARD   = 3;
  localparam logic [7:0] SEED   = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_btn = 1'b0;
  logic [2:0]    diff_in = 3'b001;
  logic [NM-1:0] sw = '0;
  logic [NM-1:0] mole_led;
  logic          start_evt, stop_evt, playing;
  logic [15:0]   score;
  logic [2:0]    diff;

  wham_round_ctrl #(
    .CLKS_PER_MS(CPM), .N_MOLES(NM), .ROUNDS(ROUNDS), .GAP_MS(GAP),
    .UP_MS_EASY(EASY), .UP_MS_MED(MED), .UP_MS_HARD(HARD), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .diff_in(diff_in), .sw(sw),
    .mole_led(mole_led), .start_evt(start_evt), .stop_evt(stop_evt),
    .score(score), .diff(diff), .playing(playing)
  );

  always #5 clk = ~clk;

  // Reference LFSR: feedback is the parity of taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  logic [7:0] lfsr_m, lfsr_prev_m;
  always @(posedge clk) begin
    lfsr_prev_m <= lfsr_m;
    lfsr_m      <= rst ? SEED : lfsr_step(lfsr_m);
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_up  = 0;
  int exp_score, exp_round, exp_playing;
  int cur_idx, prev_idx_m;
  bit have_prev_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("evt_exclusive", 32'(start_evt & stop_evt), 32'd0);
    end
  endtask

  task automatic do_start(input logic [2:0] d, input logic [2:0] exp_d);
    start_btn = 1'b1;
    diff_in   = d;
    tick(1);
    start_btn   = 1'b0;
    exp_score   = 0;
    exp_round   = 0;
    exp_playing = 1;
    chk("start_diff", 32'(diff), 32'(exp_d));
    chk("start_playing", 32'(playing), 32'd1);
    chk("start_score", 32'(score), 32'd0);
    chk("start_led_off", 32'(mole_led), 32'd0);
    chk("start_no_stop", 32'(stop_evt), 32'd0);
  endtask

  // Called on the GAP entry cycle; waits for the mole and checks which one lit.
  task automatic wait_mole(input int exp_lat);
    int n = 0;
    int m, k;
    while (!start_evt && n < 100) begin
      tick(1);
      n++;
      if (n == 3) begin
        k = $urandom_range(0, NM - 1);
        sw[k] = ~sw[k];
      end
      if (!start_evt) chk("gap_no_stop", 32'(stop_evt), 32'd0);
    end
    chk("mole_latency", 32'(n), 32'(exp_lat));
    m = int'(lfsr_prev_m) % NM;
    if (have_prev_m && m == prev_idx_m) m = (m + 1) % NM;
    prev_idx_m  = m;
    have_prev_m = 1'b1;
    cur_idx     = m;
    chk("mole_led", 32'(mole_led), 32'(1) << m);
    chk("score_at_up", 32'(score), 32'(exp_score));
    t_up = cyc;
  endtask

  task automatic after_resolve(input string tag);
    exp_round++;
    if (exp_round == ROUNDS) exp_playing = 0;
    chk({tag, "_led_off"}, 32'(mole_led), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'(exp_score));
    chk({tag, "_playing"}, 32'(playing), 32'(exp_playing));
  endtask

  task automatic hit(input bit with_wrong);
    logic [NM-1:0] t;
    int j;
    t = NM'(1) << cur_idx;
    if (with_wrong) begin
      j = (cur_idx + 1 + $urandom_range(0, NM - 2)) % NM;
      t = t | (NM'(1) << j);
    end
    chk("pre_hit_no_stop", 32'(stop_evt), 32'd0);
    sw = sw ^ t;
    tick(1);
    exp_score = (exp_score >= 9999) ? 9999 : exp_score + 1;
    chk("hit_stop", 32'(stop_evt), 32'd1);
    after_resolve("hit");
  endtask

  task automatic wrong_strike();
    int j;
    j = (cur_idx + 1 + $urandom_range(0, NM - 2)) % NM;
    sw[j] = ~sw[j];
    tick(1);
    exp_score = (exp_score > 0) ? exp_score - 1 : 0;
    chk("wrong_score", 32'(score), 32'(exp_score));
    chk("wrong_led_lit", 32'(mole_led), 32'(1) << cur_idx);
    chk("wrong_no_stop", 32'(stop_evt), 32'd0);
  endtask

  task automatic wait_timeout(input int up_ms);
    int n = 0;
    while (mole_led != '0 && n < 300) begin
      tick(1);
      n++;
      chk("up_no_stop", 32'(stop_evt), 32'd0);
    end
    chk("up_duration", 32'(cyc - t_up), 32'(up_ms * CPM));
    after_resolve("timeout");
  endtask

  initial begin
    sw = 4'($urandom);
    tick(2);
    chk("rst_led", 32'(mole_led), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_diff", 32'(diff), 32'd1);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_start", 32'(start_evt), 32'd0);
    chk("rst_stop", 32'(stop_evt), 32'd0);
    have_prev_m = 1'b0;
    prev_idx_m  = 0;
    rst = 1'b0;
    tick(1);

    // Game 1: medium. Hit, two wrong strikes then timeout, combined hit+wrong.
    do_start(3'b010, 3'b010);
    wait_mole(GAP * CPM);
    tick($urandom_range(1, 15));
    hit(1'b0);
    wait_mole(GAP * CPM);
    tick($urandom_range(1, 4));
    wrong_strike();
    tick(1);
    wrong_strike();
    wait_timeout(MED);
    wait_mole(GAP * CPM);
    tick($urandom_range(1, 10));
    hit(1'b1);
    for (int i = 0; i < 12; i++) begin
      int k;
      k = $urandom_range(0, NM - 1);
      sw[k] = ~sw[k];
      tick(1);
      chk("idle_no_start", 32'(start_evt), 32'd0);
      chk("idle_score_hold", 32'(score), 32'(exp_score));
    end
    chk("idle_diff_hold", 32'(diff), 32'd2);

    // Game 2: invalid difficulty falls back to easy; saturation at 9999.
    do_start(3'b110, 3'b001);
    diff_in = 3'b100;
    wait_mole(GAP * CPM);
    wait_timeout(EASY);
    chk("diff_ignored", 32'(diff), 32'd1);
    wait_mole(GAP * CPM);
    force dut.score_reg = 16'd9998;
    tick(1);
    release dut.score_reg;
    exp_score = 9998;
    tick(2);
    chk("preload_score", 32'(score), 32'd9998);
    hit(1'b0);
    wait_mole(GAP * CPM);
    tick(3);
    hit(1'b0);

    // Game 3: hard. Hit on the timeout cycle, restart mid-UP, reset mid-UP.
    do_start(3'b100, 3'b100);
    wait_mole(GAP * CPM);
    tick(HARD * CPM - 1);
    hit(1'b0);
    wait_mole(GAP * CPM);
    tick(2);
    do_start(3'b001, 3'b001);
    wait_mole(GAP * CPM);
    tick(2);
    rst = 1'b1;
    tick(1);
    have_prev_m = 1'b0;
    chk("mid_rst_led", 32'(mole_led), 32'd0);
    chk("mid_rst_score", 32'(score), 32'd0);
    chk("mid_rst_diff", 32'(diff), 32'd1);
    chk("mid_rst_playing", 32'(playing), 32'd0);
    chk("mid_rst_start", 32'(start_evt), 32'd0);
    chk("mid_rst_stop", 32'(stop_evt), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_start", 32'(start_evt), 32'd0);
    chk("post_rst_stop", 32'(stop_evt), 32'd0);
    do_start(3'b010, 3'b010);
    wait_mole(GAP * CPM);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
